// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite port between fetch and load/store.
// Min latency 3 cycles req-to-done; grant held until done, loser waits with req high; waits abort at TIMEOUT.
module mem_bus_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_done,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic        ARvalid,
    input  logic        ARready,
    output logic [31:0] ARdata,
    output logic [2:0]  arprot,
    input  logic        Rvalid,
    output logic        RReady,
    input  logic [31:0] Rdata_mem,
    output logic        AWvalid,
    input  logic        AWready,
    output logic [31:0] AWdata,
    output logic [2:0]  awprot,
    output logic        Wvalid,
    input  logic        Wready,
    output logic [31:0] Wdata,
    output logic [3:0]  Wstrb,
    input  logic        Bvalid,
    output logic        Bready
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RADDR = 3'd1,
        S_RDATA = 3'd2,
        S_WRITE = 3'd3,
        S_WRESP = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             gnt_d;
    logic             last_gnt;
    logic [CNT_W-1:0] cnt;
    logic             aw_ok;
    logic             w_ok;
    logic [31:0]      addr_q;
    logic [2:0]       prot_q;
    logic             grant_vld;
    logic             grant_d;
    logic             timeout_hit;
    logic             timeout_abort;
    logic             write_complete;

    // On contention the requester opposite the previous winner is served.
    assign grant_vld      = i_req | d_req;
    assign grant_d        = d_req & (~i_req | ~last_gnt);
    assign timeout_hit    = (cnt == CNT_W'(TIMEOUT - 1));
    assign write_complete = (aw_ok | (AWvalid & AWready)) & (w_ok | (Wvalid & Wready));

    assign ARvalid = (state == S_RADDR);
    assign RReady  = (state == S_RDATA);
    assign AWvalid = (state == S_WRITE) & ~aw_ok;
    assign Wvalid  = (state == S_WRITE) & ~w_ok;
    assign Bready  = (state == S_WRESP);
    assign i_done  = (state == S_RESP) & ~gnt_d;
    assign d_done  = (state == S_RESP) & gnt_d;
    assign ARdata  = addr_q;
    assign AWdata  = addr_q;
    assign arprot  = prot_q;
    assign awprot  = prot_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        timeout_abort = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant_vld) begin
                    state_nxt = (grant_d && d_we) ? S_WRITE : S_RADDR;
                end
            end
            S_RADDR: begin
                if (ARready) begin
                    state_nxt = S_RDATA;
                end else if (timeout_hit) begin
                    state_nxt     = S_RESP;
                    timeout_abort = 1'b1;
                end
            end
            S_RDATA: begin
                if (Rvalid) begin
                    state_nxt = S_RESP;
                end else if (timeout_hit) begin
                    state_nxt     = S_RESP;
                    timeout_abort = 1'b1;
                end
            end
            S_WRITE: begin
                if (write_complete) begin
                    state_nxt = S_WRESP;
                end else if (timeout_hit) begin
                    state_nxt     = S_RESP;
                    timeout_abort = 1'b1;
                end
            end
            S_WRESP: begin
                if (Bvalid) begin
                    state_nxt = S_RESP;
                end else if (timeout_hit) begin
                    state_nxt     = S_RESP;
                    timeout_abort = 1'b1;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            gnt_d    <= 1'b0;
            last_gnt <= 1'b0;
            addr_q   <= '0;
            prot_q   <= '0;
            Wdata    <= '0;
            Wstrb    <= '0;
            aw_ok    <= 1'b0;
            w_ok     <= 1'b0;
            cnt      <= '0;
            err      <= 1'b0;
            i_rdata  <= '0;
            d_rdata  <= '0;
        end else begin
            if (state == S_IDLE && grant_vld) begin
                gnt_d    <= grant_d;
                last_gnt <= grant_d;
                addr_q   <= grant_d ? d_addr : i_addr;
                prot_q   <= grant_d ? 3'b000 : 3'b100;
                Wdata    <= d_wdata;
                Wstrb    <= d_wstrb;
                aw_ok    <= 1'b0;
                w_ok     <= 1'b0;
            end
            if (state == S_WRITE) begin
                if (AWvalid && AWready) aw_ok <= 1'b1;
                if (Wvalid && Wready)   w_ok  <= 1'b1;
            end
            // Counter measures time spent in the current wait state only.
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (state inside {S_RADDR, S_RDATA, S_WRITE, S_WRESP}) begin
                cnt <= cnt + CNT_W'(1);
            end
            err <= timeout_abort;
            if (timeout_abort) begin
                if (gnt_d) d_rdata <= '0;
                else       i_rdata <= '0;
            end else if (state == S_RDATA && Rvalid) begin
                if (gnt_d) d_rdata <= Rdata_mem;
                else       i_rdata <= Rdata_mem;
            end
        end
    end

endmodule
